// File: rtl/multinoc_inject_sched_pkg.sv
// -----------------------------------------------------------------------------
// multinoc_inject_sched_pkg
// Shared constants for the dual-subnet injection scheduler. The flit and PV
// widths are the same values the BLESS router ports are built with, so the
// scheduler outputs can be wired straight into dinLocal*/PVLocal*.
// Also holds the subnet index constants and the pop-count type.
// -----------------------------------------------------------------------------
package multinoc_inject_sched_pkg;

    localparam int FLIT_W_C = 64;   // router port width
    localparam int PV_W_C   = 5;    // productive-vector width

    // Subnet indices: subnet 0 feeds dinLocal1/PVLocal1, subnet 1 feeds
    // dinLocal2/PVLocal2.
    localparam logic SUBNET0 = 1'b0;
    localparam logic SUBNET1 = 1'b1;

    // Number of entries leaving the FIFO in one cycle: 0, 1 or 2.
    typedef logic [1:0] pop_cnt_t;

endpackage

// File: rtl/multinoc_inject_sched_if.sv
// -----------------------------------------------------------------------------
// multinoc_inject_sched_if
// Bundles the injection stream, the subnet-free indications and the two
// local-port output channels of the injection scheduler.
//   master : the node side (drives inj_*, slot_free; observes everything else)
//   slave  : the scheduler (accepts inj_*, slot_free; drives ready/outputs)
// Signals:
//   inj_valid/inj_flit/inj_pv/inj_ready : injection handshake
//   slot_free[1:0]                      : subnet i local port free next cycle
//   out_valid[1:0], out_flit0/out_pv0, out_flit1/out_pv1 : per-subnet outputs
//   occupancy                           : current FIFO count
//   starve                              : head-of-line starvation flag
// -----------------------------------------------------------------------------
interface multinoc_inject_sched_if
    import multinoc_inject_sched_pkg::*;
#(
    parameter int FLIT_W = FLIT_W_C,
    parameter int PV_W   = PV_W_C,
    parameter int OCC_W  = 3
);
    logic              inj_valid;
    logic [FLIT_W-1:0] inj_flit;
    logic [PV_W-1:0]   inj_pv;
    logic              inj_ready;
    logic [1:0]        slot_free;
    logic [1:0]        out_valid;
    logic [FLIT_W-1:0] out_flit0;
    logic [PV_W-1:0]   out_pv0;
    logic [FLIT_W-1:0] out_flit1;
    logic [PV_W-1:0]   out_pv1;
    logic [OCC_W-1:0]  occupancy;
    logic              starve;

    modport master (
        output inj_valid, inj_flit, inj_pv, slot_free,
        input  inj_ready, out_valid, out_flit0, out_pv0, out_flit1, out_pv1,
               occupancy, starve
    );

    modport slave (
        input  inj_valid, inj_flit, inj_pv, slot_free,
        output inj_ready, out_valid, out_flit0, out_pv0, out_flit1, out_pv1,
               occupancy, starve
    );
endinterface

// File: rtl/multinoc_inject_sched_inj_fifo.sv
// -----------------------------------------------------------------------------
// multinoc_inject_sched_inj_fifo
// Injection FIFO holding DEPTH entries of {pv,flit}. Exposes the head and the
// entry behind it so the scheduler can issue up to two flits per cycle.
// Ports:
//   clk, reset (async, active-low)
//   push, wr_data      : write one entry (caller guarantees count < DEPTH)
//   pop_cnt            : entries removed this cycle (0/1/2, <= count)
//   rd_data0, rd_data1 : head and head+1 (head+1 meaningful only if count>=2)
//   count              : number of stored entries
// The read is combinational; the scheduler's output registers act as the
// registered read stage.
// -----------------------------------------------------------------------------
module multinoc_inject_sched_inj_fifo
    import multinoc_inject_sched_pkg::*;
#(
    parameter int W     = FLIT_W_C + PV_W_C,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               wr_data,
    input  pop_cnt_t                   pop_cnt,
    output logic [W-1:0]               rd_data0,
    output logic [W-1:0]               rd_data1,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_p1;
    logic [CW-1:0] count_reg;

    // DEPTH is a power of two, so pointer arithmetic wraps naturally.
    assign rd_ptr_p1 = rd_ptr_reg + AW'(1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_reg + AW'(pop_cnt);
            count_reg  <= count_reg + CW'(push) - CW'(pop_cnt);
        end
    end

    assign rd_data0 = mem[rd_ptr_reg];
    assign rd_data1 = mem[rd_ptr_p1];
    assign count    = count_reg;

endmodule

// File: rtl/multinoc_inject_sched.sv
// -----------------------------------------------------------------------------
// multinoc_inject_sched
// Local-injection scheduler for a dual-subnet BLESS node. Buffers the node's
// injection stream and dispatches flits to whichever subnet local port is
// free: round-robin when both are free, dual-issue when two flits are queued.
// Flags head-of-line starvation when the head waits STARVE_LIMIT cycles.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   bus        : multinoc_inject_sched_if.slave (injection handshake,
//                slot_free, two output channels, occupancy, starve)
//   disp_cnt0/disp_cnt1 : per-subnet dispatch counters (INJ_STATS_EN only)
// Build option: define INJ_STATS_EN to add the 16-bit dispatch counters.
// -----------------------------------------------------------------------------
module multinoc_inject_sched
    import multinoc_inject_sched_pkg::*;
#(
    parameter int FLIT_W       = FLIT_W_C,
    parameter int PV_W         = PV_W_C,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    multinoc_inject_sched_if.slave bus
`ifdef INJ_STATS_EN
    ,
    output logic [15:0]            disp_cnt0,
    output logic [15:0]            disp_cnt1
`endif
);
    localparam int OCC_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = PV_W + FLIT_W;
    localparam logic [OCC_W-1:0] DEPTH_C   = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] ONE_C     = OCC_W'(1);
    localparam logic [CNT_W-1:0] STARVE_TH = CNT_W'(STARVE_LIMIT);

    logic [OCC_W-1:0]   count;
    logic               inj_ready;
    logic               push;
    pop_cnt_t           pop_cnt;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] head1;

    logic               rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]   wait_reg, wait_next;
    logic               starve_reg;
    logic [1:0]         valid_next;
    logic [ENTRY_W-1:0] data_next [2];

    // No full-bypass: a pop in this cycle does not make room for a push.
    assign inj_ready = (count < DEPTH_C);
    assign push      = bus.inj_valid & inj_ready;

    multinoc_inject_sched_inj_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .wr_data  ({bus.inj_pv, bus.inj_flit}),
        .pop_cnt  (pop_cnt),
        .rd_data0 (head),
        .rd_data1 (head1),
        .count    (count)
    );

    // Dispatch decision on the registered count and current slot_free.
    always_comb begin
        pop_cnt      = 2'd0;
        rr_ptr_next  = rr_ptr_reg;
        valid_next   = 2'b00;
        data_next[0] = '0;
        data_next[1] = '0;
        if (count != '0) begin
            case (bus.slot_free)
                2'b01: begin
                    pop_cnt      = 2'd1;
                    valid_next   = 2'b01;
                    data_next[0] = head;
                    rr_ptr_next  = SUBNET1;
                end
                2'b10: begin
                    pop_cnt      = 2'd1;
                    valid_next   = 2'b10;
                    data_next[1] = head;
                    rr_ptr_next  = SUBNET0;
                end
                2'b11: begin
                    rr_ptr_next = ~rr_ptr_reg;
                    if (count == ONE_C) begin
                        pop_cnt = 2'd1;
                        if (rr_ptr_reg == SUBNET0) begin
                            valid_next   = 2'b01;
                            data_next[0] = head;
                        end else begin
                            valid_next   = 2'b10;
                            data_next[1] = head;
                        end
                    end else begin
                        // Head to the favoured subnet, head+1 to the other.
                        pop_cnt      = 2'd2;
                        valid_next   = 2'b11;
                        data_next[0] = (rr_ptr_reg == SUBNET0) ? head  : head1;
                        data_next[1] = (rr_ptr_reg == SUBNET0) ? head1 : head;
                    end
                end
                default: ;
            endcase
        end
    end

    // Head wait counter: saturating, cleared on any pop or when empty.
    always_comb begin
        wait_next = wait_reg;
        if (count == '0 || pop_cnt != 2'd0) begin
            wait_next = '0;
        end else if (wait_reg != {CNT_W{1'b1}}) begin
            wait_next = wait_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg <= SUBNET0;
            wait_reg   <= '0;
            starve_reg <= 1'b0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            wait_reg   <= wait_next;
            // Registered from the next counter value so starve tracks the
            // counter exactly and drops right after the popping edge.
            starve_reg <= (wait_next >= STARVE_TH);
        end
    end

    // Per-subnet output registers; an idle port is loaded with zeros.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_port
        logic               valid_reg;
        logic [ENTRY_W-1:0] data_reg;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
            end else begin
                valid_reg <= valid_next[gi];
                data_reg  <= data_next[gi];
            end
        end
    end

    assign bus.out_valid = {g_port[1].valid_reg, g_port[0].valid_reg};
    assign bus.out_flit0 = g_port[0].data_reg[FLIT_W-1:0];
    assign bus.out_pv0   = g_port[0].data_reg[ENTRY_W-1:FLIT_W];
    assign bus.out_flit1 = g_port[1].data_reg[FLIT_W-1:0];
    assign bus.out_pv1   = g_port[1].data_reg[ENTRY_W-1:FLIT_W];
    assign bus.inj_ready = inj_ready;
    assign bus.occupancy = count;
    assign bus.starve    = starve_reg;

`ifdef INJ_STATS_EN
    // Dispatch counters, bumped at the same edge the output registers load.
    for (gi = 0; gi < 2; gi++) begin : g_stats
        logic [15:0] cnt_reg;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 16'(valid_next[gi]);
            end
        end
    end

    assign disp_cnt0 = g_stats[0].cnt_reg;
    assign disp_cnt1 = g_stats[1].cnt_reg;
`endif

endmodule

// File: tb/tb_multinoc_inject_sched.sv
// -----------------------------------------------------------------------------
// tb_multinoc_inject_sched
// Directed bench for the dual-subnet injection scheduler. Stimulus pushes the
// expected {pv,flit} per subnet into a queue; an independent negedge monitor
// pops and compares whenever a subnet output is valid, and checks idle ports
// carry zeros. Inline checks cover ready, occupancy, out_valid and starve.
// -----------------------------------------------------------------------------
module tb_multinoc_inject_sched;

    typedef logic [68:0] ent_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    ent_t q0[$];
    ent_t q1[$];

    always #5 clk = ~clk;

    multinoc_inject_sched_if #(.FLIT_W(64), .PV_W(5), .OCC_W(3)) bus ();

`ifdef INJ_STATS_EN
    logic [15:0] disp_cnt0;
    logic [15:0] disp_cnt1;
`endif

    multinoc_inject_sched #(
        .FLIT_W       (64),
        .PV_W         (5),
        .DEPTH        (4),
        .STARVE_LIMIT (8),
        .CNT_W        (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef INJ_STATS_EN
        ,
        .disp_cnt0 (disp_cnt0),
        .disp_cnt1 (disp_cnt1)
`endif
    );

    task automatic chk(input string name, input ent_t act, input ent_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the flit until accepted (bounded), then release the stream.
    task automatic push(input logic [63:0] f, input logic [4:0] p);
        int n;
        n = 0;
        bus.inj_valid = 1'b1;
        bus.inj_flit  = f;
        bus.inj_pv    = p;
        while (!bus.inj_ready && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: inj_ready stayed 0 for flit %0h, required 1", f);
        end
        step();
        bus.inj_valid = 1'b0;
        bus.inj_flit  = '0;
        bus.inj_pv    = '0;
    endtask

    task automatic port_chk(input int p, input logic v, input ent_t act);
        ent_t e;
        bit   empty;
        empty = (p == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (v) begin
            if (empty) begin
                tests++;
                fails++;
                $display("FAIL out%0d_unexpected: got flit %0h, required no dispatch", p, act);
            end else begin
                if (p == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("out%0d_data", p), act, e);
            end
        end else if (act !== '0) begin
            tests++;
            fails++;
            $display("FAIL out%0d_idle_zero: got %0h, required 0", p, act);
        end
    endtask

    // Monitor: independent of stimulus timing.
    always @(negedge clk) begin
        if (reset) begin
            port_chk(0, bus.out_valid[0], {bus.out_pv0, bus.out_flit0});
            port_chk(1, bus.out_valid[1], {bus.out_pv1, bus.out_flit1});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] f;
`ifdef INJ_STATS_EN
        logic [15:0] c1;
`endif
        reset         = 1'b0;
        bus.inj_valid = 1'b0;
        bus.inj_flit  = '0;
        bus.inj_pv    = '0;
        bus.slot_free = 2'b00;

        // ---- Reset held with a flit offered ----
        bus.inj_valid = 1'b1;
        bus.inj_flit  = 64'hAA00_0000_0000_0001;
        bus.inj_pv    = 5'b00001;
        repeat (3) step();
        chk_i("rst_inj_ready", int'(bus.inj_ready), 1);
        chk_i("rst_out_valid", int'(bus.out_valid), 0);
        chk_i("rst_occupancy", int'(bus.occupancy), 0);
        chk_i("rst_starve", int'(bus.starve), 0);
        reset = 1'b1;
        step();
        chk_i("first_push_occ", int'(bus.occupancy), 1);
        bus.inj_valid = 1'b0;
        bus.slot_free = 2'b01;
        q0.push_back({5'b00001, 64'hAA00_0000_0000_0001});
        step();
        chk_i("first_disp_valid", int'(bus.out_valid), 1);
        bus.slot_free = 2'b00;
        step();                                   // rr_ptr = 1

        // ---- Single subnet 0, latency 2 ----
        bus.slot_free = 2'b01;
        q0.push_back({5'b00010, 64'h0000_0000_0000_000A});
        push(64'h0000_0000_0000_000A, 5'b00010);
        chk_i("no_flow_through", int'(bus.out_valid), 0);
        step();
        chk_i("single0_valid", int'(bus.out_valid), 1);
        chk_i("single0_occ", int'(bus.occupancy), 0);
        bus.slot_free = 2'b00;                    // rr_ptr = 1

        // ---- Single subnet 1 ----
        bus.slot_free = 2'b10;
        q1.push_back({5'b00100, 64'h0000_0000_0000_000D});
        push(64'h0000_0000_0000_000D, 5'b00100);
        step();
        chk_i("single1_valid", int'(bus.out_valid), 2);
        bus.slot_free = 2'b00;                    // rr_ptr = 0

        // ---- Dual issue with rr_ptr = 0 ----
        push(64'h0000_0000_0000_00A2, 5'b01000);
        push(64'h0000_0000_0000_00B2, 5'b10000);
        chk_i("dual_preload_occ", int'(bus.occupancy), 2);
        bus.slot_free = 2'b11;
        q0.push_back({5'b01000, 64'h0000_0000_0000_00A2});
        q1.push_back({5'b10000, 64'h0000_0000_0000_00B2});
        step();
        chk_i("dual_valid", int'(bus.out_valid), 3);
        chk_i("dual_occ", int'(bus.occupancy), 0);
        bus.slot_free = 2'b00;                    // rr_ptr = 1

        // ---- Round-robin: 3 flits, rr_ptr = 1 ----
        push(64'hC000_0000_0000_0001, 5'b00001);
        push(64'hC000_0000_0000_0002, 5'b00010);
        push(64'hC000_0000_0000_0003, 5'b00011);
        chk_i("rr_preload_occ", int'(bus.occupancy), 3);
        bus.slot_free = 2'b11;
        q1.push_back({5'b00001, 64'hC000_0000_0000_0001});
        q0.push_back({5'b00010, 64'hC000_0000_0000_0002});
        q0.push_back({5'b00011, 64'hC000_0000_0000_0003});
        step();
        chk_i("rr_first_valid", int'(bus.out_valid), 3);
        chk_i("rr_first_occ", int'(bus.occupancy), 1);
        step();
        chk_i("rr_second_valid", int'(bus.out_valid), 1);
        chk_i("rr_second_occ", int'(bus.occupancy), 0);
        bus.slot_free = 2'b00;                    // rr_ptr = 1

        // ---- Full / backpressure ----
        for (int i = 0; i < 4; i++) begin
            push(64'hF000_0000_0000_0000 + 64'(i), 5'(i + 1));
        end
        chk_i("full_occ", int'(bus.occupancy), 4);
        chk_i("full_ready", int'(bus.inj_ready), 0);
        bus.inj_valid = 1'b1;
        bus.inj_flit  = 64'hF000_0000_0000_0004;
        bus.inj_pv    = 5'd5;
        repeat (3) step();
        chk_i("held_not_taken", int'(bus.occupancy), 4);
        bus.slot_free = 2'b01;
        q0.push_back({5'd1, 64'hF000_0000_0000_0000});
        step();
        chk_i("pop_no_bypass_occ", int'(bus.occupancy), 3);
        chk_i("pop_frees_ready", int'(bus.inj_ready), 1);
        bus.slot_free = 2'b00;
        step();
        chk_i("held_taken_occ", int'(bus.occupancy), 4);
        bus.inj_valid = 1'b0;
        bus.inj_flit  = '0;
        bus.inj_pv    = '0;                        // rr_ptr = 1
        q1.push_back({5'd2, 64'hF000_0000_0000_0001});
        q0.push_back({5'd3, 64'hF000_0000_0000_0002});
        q0.push_back({5'd4, 64'hF000_0000_0000_0003});
        q1.push_back({5'd5, 64'hF000_0000_0000_0004});
        bus.slot_free = 2'b11;
        step();
        step();
        chk_i("full_drain_occ", int'(bus.occupancy), 0);
        bus.slot_free = 2'b00;                    // rr_ptr = 1

        // ---- Pointer wrap: 10 flits streamed to subnet 0 ----
        bus.slot_free = 2'b01;
        for (int i = 0; i < 10; i++) begin
            f = 64'h5700_0000_0000_0000 + 64'(i);
            q0.push_back({5'(i), f});
            push(f, 5'(i));
        end
        step();
        step();
        chk_i("wrap_drain_occ", int'(bus.occupancy), 0);
        bus.slot_free = 2'b00;

        // ---- Starvation ----
        push(64'h5A5A_0000_0000_0001, 5'b10101);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk_i($sformatf("starve_cyc%0d", k), int'(bus.starve), (k >= 8) ? 1 : 0);
        end
`ifdef INJ_STATS_EN
        c1 = disp_cnt1;
`endif
        bus.slot_free = 2'b10;
        q1.push_back({5'b10101, 64'h5A5A_0000_0000_0001});
        step();
        chk_i("starve_clear", int'(bus.starve), 0);
        chk_i("starve_disp_valid", int'(bus.out_valid), 2);
`ifdef INJ_STATS_EN
        chk_i("disp_cnt1_inc", int'(disp_cnt1), int'(c1) + 1);
`endif
        bus.slot_free = 2'b00;

        // ---- Reset mid-operation ----
        push(64'h6000_0000_0000_0000, 5'b00110);
        push(64'h6000_0000_0000_0001, 5'b00111);
        bus.slot_free = 2'b01;
        step();
        chk("midrst_pre_data", {bus.out_pv0, bus.out_flit0},
            {5'b00110, 64'h6000_0000_0000_0000});
        reset = 1'b0;
        #1;
        chk_i("midrst_out_valid", int'(bus.out_valid), 0);
        chk_i("midrst_occ", int'(bus.occupancy), 0);
        chk_i("midrst_ready", int'(bus.inj_ready), 1);
        bus.slot_free = 2'b00;
        step();
        reset = 1'b1;
        step();
        step();
        chk_i("q0_drained", q0.size(), 0);
        chk_i("q1_drained", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multinoc_inject_sched.md
Name: multinoc_inject_sched

Overview:
Local-injection scheduler for a dual-subnet (multi-NoC) node, where two bufferless BLESS routers are cross-linked by a bypass channel. It buffers flits from the node's single injection stream and dispatches each one to whichever subnet's local input port is free. Dispatch is round-robin, with dual-issue when both subnets are free. Outputs drive the routers' dinLocal1/PVLocal1 and dinLocal2/PVLocal2 inputs, and it flags head-of-line starvation.

Parameters:
FLIT_W, 64, flit width; equals the shared router port-width constant
PV_W, 5, productive-vector width; equals the shared PV-width constant
DEPTH, 4, FIFO entries; power of 2, minimum 2
STARVE_LIMIT, 8, head-wait cycles before starve asserts
CNT_W, 4, wait-counter width; must hold STARVE_LIMIT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
inj_valid  in  1  injection flit valid
inj_flit  in  FLIT_W  injection flit
inj_pv  in  PV_W  productive vector of injection flit
inj_ready  out  1  FIFO can accept a flit this cycle
slot_free  in  2  bit i: subnet i local port can take a flit next cycle
out_valid  out  2  bit i: out_flit_i/out_pv_i valid this cycle
out_flit0  out  FLIT_W  flit to subnet 0 (dinLocal1)
out_pv0  out  PV_W  PV to subnet 0 (PVLocal1)
out_flit1  out  FLIT_W  flit to subnet 1 (dinLocal2)
out_pv1  out  PV_W  PV to subnet 1 (PVLocal2)
occupancy  out  log2(DEPTH)+1  current FIFO count
starve  out  1  head waited >= STARVE_LIMIT cycles

Behaviour:
- Reset (reset=0, async): FIFO empty, rd/wr pointers 0, rr_ptr=0, wait counter 0. Outputs: out_valid=0, out_flit*/out_pv*=0, starve=0, occupancy=0, inj_ready=1.
- When out_valid[i]=0, out_flit_i and out_pv_i are driven to 0; an idle port never shows stale data.
- inj_ready = (count < DEPTH), computed from the current count; a pop in the same cycle does not free a slot (no full-bypass).
- Push: inj_valid & inj_ready writes {flit,pv} at wr_ptr; the pointer wraps modulo DEPTH.
- inj_valid while inj_ready=0: flit is not accepted; the source must hold it.
- Dispatch decision each cycle, on registered count and slot_free:
  - count=0 or slot_free=00: no pop; out_valid=00 next cycle.
  - Exactly one bit i of slot_free set: pop head to subnet i; rr_ptr <= ~i.
  - slot_free=11 and count=1: pop head to subnet rr_ptr; rr_ptr toggles.
  - slot_free=11 and count>=2: head goes to subnet rr_ptr and head+1 to the other subnet; rd_ptr advances 2 with wrap; rr_ptr toggles.
- Output registers load at the dispatch edge, so flits appear one cycle after the decision. Minimum latency from accepted push to out_valid is 2 cycles; an empty FIFO has no flow-through.
- Simultaneous push and pop: count <= count + push - pops, where pops is 0, 1 or 2.
- Wait counter:
  - Increments, saturating at 2^CNT_W-1, when count>0 and no pop occurs.
  - Clears on any pop and whenever count=0.
  - starve is registered; it equals 1 when the counter >= STARVE_LIMIT and drops the cycle after a pop.
- Reset mid-operation: buffered flits are discarded and out_valid drops immediately (async).

Optional Feature:
INJ_STATS_EN
- Defined: adds outputs disp_cnt0 and disp_cnt1 (16 bits each). Each counts flits dispatched to that subnet, wraps at 0xFFFF->0, and is cleared by reset.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package/include holds the flit-width and PV-width constants (same source as the router) and a subnet-index constant for subnets 0 and 1.
- One sub-module: inj_fifo.
  - Stores DEPTH entries of {pv,flit}.
  - Provides a one- or two-entry read port (head, head+1) and a pop count input of 0/1/2.
  - Outputs count.
- The scheduler top holds rr_ptr, the wait counter and the output registers.

Test Plan:
- Reset: hold reset=0 with inj_valid=1 -> inj_ready=1, out_valid=00, occupancy=0, starve=0. Release -> first push visible as occupancy=1 one cycle later.
- Single subnet: push A (pv=5'b00010), slot_free=01 -> out_valid=01, out_flit0=A two cycles after push; rr_ptr=1.
- Dual issue: preload A,B (occupancy=2), rr_ptr=0, slot_free=11 -> next cycle out_flit0=A, out_flit1=B, out_valid=11, occupancy=0.
- Round-robin: preload A,B,C, slot_free=11 held with one push per cycle stalled -> dispatch A->0/B->1, then C->1 (rr_ptr toggled). Also verify DEPTH=4 wrap order over 10 flits.
- Full/backpressure: slot_free=00, push 4 flits -> inj_ready=0 at occupancy=4. A 5th flit held by the source is accepted only after a pop frees a slot.
- Starvation: 1 flit, slot_free=00 for 10 cycles -> starve=1 from cycle 8 on. Set slot_free=10 -> flit on out_flit1, starve=0 the following cycle. With INJ_STATS_EN, disp_cnt1 increments by 1.
